// File: rtl/cxs_rx_link_endpoint_if.sv
// CXS receive channel plus the card-side flit stream, seen from the transmitter (master)
// and from the receive endpoint (slave).
interface cxs_rx_link_endpoint_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned CW = 14
);
  logic          cxs_active_req_rx;
  logic          cxs_active_ack_rx;
  logic          cxs_deact_hint_rx;
  logic          cxs_valid_rx;
  logic [DW-1:0] cxs_data_rx;
  logic [CW-1:0] cxs_cntl_rx;
  logic [DW/8-1:0] cxs_data_chk_rx;
  logic          cxs_crdrtn_rx;
  logic          cxs_crdgnt_rx;
  logic          cxs_crdgnt_chk_rx;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic [CW-1:0] rx_cntl;

  modport master (
    output cxs_active_req_rx, cxs_valid_rx, cxs_data_rx, cxs_cntl_rx, cxs_data_chk_rx,
           cxs_crdrtn_rx, rx_ready,
    input  cxs_active_ack_rx, cxs_deact_hint_rx, cxs_crdgnt_rx, cxs_crdgnt_chk_rx,
           rx_valid, rx_data, rx_cntl
  );

  modport slave (
    input  cxs_active_req_rx, cxs_valid_rx, cxs_data_rx, cxs_cntl_rx, cxs_data_chk_rx,
           cxs_crdrtn_rx, rx_ready,
    output cxs_active_ack_rx, cxs_deact_hint_rx, cxs_crdgnt_rx, cxs_crdgnt_chk_rx,
           rx_valid, rx_data, rx_cntl
  );
endinterface

// File: rtl/cxs_rx_link_endpoint.sv
// Receive-side CXS endpoint: activation handshake, credit grants against free buffer space,
// flit FIFO with show-ahead stream output, and sticky parity/protocol error flags.
module cxs_rx_link_endpoint #(
  parameter int unsigned CXS_DATA_FLIT_WIDTH = 256,
  parameter int unsigned CXS_CNTL_WIDTH      = 14,
  parameter bit          CXS_DATACHECK       = 1'b0,
  parameter int unsigned MAX_CRD             = 15,
  parameter int unsigned FIFO_DEPTH          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  cxs_rx_link_endpoint_if.slave        cxs,
  input  logic                         usr_deact_req,
  output logic [1:0]                   link_state,
  output logic [3:0]                   crd_outstanding,
  output logic                         err_proto,
  output logic                         err_parity,
  input  logic                         err_clr
);
  localparam int unsigned DW = CXS_DATA_FLIT_WIDTH;
  localparam int unsigned CW = CXS_CNTL_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] StStop  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDeact = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ack_q, gnt_q, gnt_d, hint_q;
  logic [3:0]       crd_q, crd_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q, fifo_count;
  logic [AW+4:0]    occupancy;
  logic [DW+CW-1:0] mem [FIFO_DEPTH];
  logic             fifo_nempty, push, pop;
  logic             valid_acc, valid_err, rtn_acc, rtn_err, req_err, par_bad;
  logic             err_proto_q, err_parity_q;

  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_nempty = (fifo_count != '0);
  assign occupancy   = (AW+5)'(fifo_count) + (AW+5)'(crd_q);

  // A flit needs a visible credit; a same-cycle return may only use what the flit left over.
  assign valid_acc = cxs.cxs_valid_rx & (state_q != StStop) & (crd_q != 4'd0);
  assign valid_err = cxs.cxs_valid_rx & ~valid_acc;
  assign rtn_acc   = cxs.cxs_crdrtn_rx & (crd_q > 4'(valid_acc));
  assign rtn_err   = cxs.cxs_crdrtn_rx & ~rtn_acc;

  assign gnt_d = (state_q == StRun) & cxs.cxs_active_req_rx & (crd_q < 4'(MAX_CRD)) &
                 (occupancy < (AW+5)'(FIFO_DEPTH));
  assign crd_d = crd_q + 4'(gnt_d) - 4'(valid_acc) - 4'(rtn_acc);

  assign push = valid_acc;
  assign pop  = fifo_nempty & cxs.rx_ready;

  if (CXS_DATACHECK) begin : g_par
    logic [DW/8-1:0] byte_ok;
    for (genvar i = 0; i < DW/8; i++) begin : g_byte
      assign byte_ok[i] = ^{cxs.cxs_data_rx[8*i +: 8], cxs.cxs_data_chk_rx[i]};
    end
    assign par_bad = valid_acc & ~(&byte_ok);
  end else begin : g_nopar
    assign par_bad = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    req_err = 1'b0;
    case (state_q)
      StStop:  if (cxs.cxs_active_req_rx) state_d = StRun;
      StRun:   if (!cxs.cxs_active_req_rx) state_d = StDeact;
      StDeact: begin
        req_err = cxs.cxs_active_req_rx;
        if (crd_d == 4'd0) state_d = StStop;
      end
      default: state_d = StStop;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StStop;
      ack_q        <= 1'b0;
      gnt_q        <= 1'b0;
      hint_q       <= 1'b0;
      crd_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_proto_q  <= 1'b0;
      err_parity_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= (state_d != StStop);
      gnt_q        <= gnt_d;
      hint_q       <= usr_deact_req & (state_d == StRun);
      crd_q        <= crd_d;
      wr_ptr_q     <= wr_ptr_q + (AW+1)'(push);
      rd_ptr_q     <= rd_ptr_q + (AW+1)'(pop);
      // A new error in the same cycle wins over err_clr.
      err_proto_q  <= valid_err | rtn_err | req_err | (err_proto_q & ~err_clr);
      err_parity_q <= par_bad | (err_parity_q & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {cxs.cxs_data_rx, cxs.cxs_cntl_rx};
  end

  assign {cxs.rx_data, cxs.rx_cntl} = mem[rd_ptr_q[AW-1:0]];
  assign cxs.rx_valid          = fifo_nempty;
  assign cxs.cxs_active_ack_rx = ack_q;
  assign cxs.cxs_deact_hint_rx = hint_q;
  assign cxs.cxs_crdgnt_rx     = gnt_q;
  assign cxs.cxs_crdgnt_chk_rx = ~gnt_q;
  assign link_state            = state_q;
  assign crd_outstanding       = crd_q;
  assign err_proto             = err_proto_q;
  assign err_parity            = err_parity_q;
endmodule

// File: tb/tb_cxs_rx_link_endpoint.sv
// Scoreboard bench for cxs_rx_link_endpoint: a credit-obeying transmitter model pushes each
// accepted flit to a queue, and the output monitor pops and compares in order.
module tb_cxs_rx_link_endpoint;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = 14;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       usr_deact_req = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] link_state;
  logic [3:0] crd_outstanding;
  logic       err_proto, err_parity;

  cxs_rx_link_endpoint_if #(.DW(DW), .CW(CW)) cxs ();

  cxs_rx_link_endpoint #(
    .CXS_DATA_FLIT_WIDTH (DW),
    .CXS_CNTL_WIDTH      (CW),
    .CXS_DATACHECK       (1'b1),
    .MAX_CRD             (15),
    .FIFO_DEPTH          (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cxs             (cxs),
    .usr_deact_req   (usr_deact_req),
    .link_state      (link_state),
    .crd_outstanding (crd_outstanding),
    .err_proto       (err_proto),
    .err_parity      (err_parity),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gnt_seen = 0;
  int used = 0;
  logic [DW+CW-1:0] sb_q[$];
  logic [DW+CW-1:0] exp_flit;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants counted by the transmitter; flits popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      gnt_seen <= 0;
    end else begin
      if (cxs.cxs_crdgnt_rx) gnt_seen <= gnt_seen + 1;
      if (cxs.rx_valid && cxs.rx_ready) begin
        if (sb_q.size() == 0) begin
          check("rx_unexpected", DW'(cxs.rx_valid), '0);
        end else begin
          exp_flit = sb_q.pop_front();
          check("rx_data", cxs.rx_data, exp_flit[DW+CW-1:CW]);
          check("rx_cntl", DW'(cxs.rx_cntl), DW'(exp_flit[CW-1:0]));
        end
      end
    end
  end

  task automatic send_flit(input bit bad_par, input bit with_rtn);
    logic [DW-1:0]   d;
    logic [CW-1:0]   c;
    logic [DW/8-1:0] p;
    int t;
    t = 0;
    while ((gnt_seen - used) < (with_rtn ? 2 : 1) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      check("crd_wait", DW'(gnt_seen - used), DW'(1));
      return;
    end
    for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
    c = CW'($urandom);
    for (int i = 0; i < DW/8; i++) p[i] = ~(^d[8*i +: 8]);
    if (bad_par) begin
      d[7:0] = 8'h01;
      p[0]   = 1'b1;
    end
    cxs.cxs_valid_rx    = 1'b1;
    cxs.cxs_data_rx     = d;
    cxs.cxs_cntl_rx     = c;
    cxs.cxs_data_chk_rx = p;
    cxs.cxs_crdrtn_rx   = with_rtn;
    sb_q.push_back({d, c});
    used = used + (with_rtn ? 2 : 1);
    tick();
    cxs.cxs_valid_rx  = 1'b0;
    cxs.cxs_crdrtn_rx = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check(tag, DW'(sb_q.size()), '0);
  endtask

  initial begin
    int first, last;
    cxs.cxs_active_req_rx = 1'b0;
    cxs.cxs_valid_rx      = 1'b0;
    cxs.cxs_data_rx       = '0;
    cxs.cxs_cntl_rx       = '0;
    cxs.cxs_data_chk_rx   = '0;
    cxs.cxs_crdrtn_rx     = 1'b0;
    cxs.rx_ready          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", DW'(cxs.cxs_active_ack_rx), '0);
    check("rst_gnt", DW'(cxs.cxs_crdgnt_rx), '0);
    check("rst_gnt_chk", DW'(cxs.cxs_crdgnt_chk_rx), DW'(1));
    check("rst_rx_valid", DW'(cxs.rx_valid), '0);
    check("rst_state", DW'(link_state), '0);
    check("rst_crd", DW'(crd_outstanding), '0);
    check("rst_errs", DW'({err_proto, err_parity, cxs.cxs_deact_hint_rx}), '0);
    tick();
    reset = 1'b0;

    // T1: activation and initial credit burst
    tick();
    cxs.cxs_active_req_rx = 1'b1;
    @(negedge clk);
    check("t1_ack_before", DW'(cxs.cxs_active_ack_rx), '0);
    @(negedge clk);
    check("t1_ack", DW'(cxs.cxs_active_ack_rx), DW'(1));
    check("t1_state_run", DW'(link_state), DW'(1));
    first = -1;
    last  = -1;
    for (int i = 0; i < 30; i++) begin
      if (cxs.cxs_crdgnt_rx) begin
        if (first < 0) first = i;
        last = i;
        check("t1_gnt_chk", DW'(cxs.cxs_crdgnt_chk_rx), '0);
      end
      @(negedge clk);
    end
    tick();
    check("t1_gnt_count", DW'(gnt_seen), DW'(15));
    check("t1_gnt_back_to_back", DW'(last - first), DW'(14));
    check("t1_crd", DW'(crd_outstanding), DW'(15));

    // T2: fill FIFO with output stalled, then drain
    for (int i = 0; i < 16; i++) send_flit(1'b0, 1'b0);
    repeat (10) tick();
    check("t2_gnt_stop", DW'(gnt_seen), DW'(16));
    check("t2_crd_zero", DW'(crd_outstanding), '0);
    check("t2_rx_valid", DW'(cxs.rx_valid), DW'(1));
    check("t2_no_err", DW'({err_proto, err_parity}), '0);
    cxs.rx_ready = 1'b1;
    wait_drain("t2_drain");
    repeat (20) tick();
    check("t2_gnt_resume", DW'(gnt_seen), DW'(31));
    check("t2_crd_refill", DW'(crd_outstanding), DW'(15));

    // T3: deactivation with 5 credits outstanding
    cxs.rx_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_flit(1'b0, 1'b0);
    repeat (5) tick();
    check("t3_crd5", DW'(crd_outstanding), DW'(5));
    usr_deact_req = 1'b1;
    tick();
    check("t3_hint", DW'(cxs.cxs_deact_hint_rx), DW'(1));
    cxs.cxs_active_req_rx = 1'b0;
    usr_deact_req = 1'b0;
    tick();
    check("t3_state_deact", DW'(link_state), DW'(2));
    check("t3_ack_held", DW'(cxs.cxs_active_ack_rx), DW'(1));
    check("t3_hint_off", DW'(cxs.cxs_deact_hint_rx), '0);
    repeat (3) tick();
    check("t3_no_gnt", DW'(gnt_seen), DW'(32));
    send_flit(1'b0, 1'b0);
    send_flit(1'b0, 1'b1);
    send_flit(1'b0, 1'b0);
    check("t3_still_deact", DW'(link_state), DW'(2));
    cxs.cxs_crdrtn_rx = 1'b1;
    used++;
    tick();
    cxs.cxs_crdrtn_rx = 1'b0;
    check("t3_stop", DW'(link_state), '0);
    check("t3_ack_low", DW'(cxs.cxs_active_ack_rx), '0);
    check("t3_crd0", DW'(crd_outstanding), '0);
    check("t3_no_proto", DW'(err_proto), '0);
    cxs.rx_ready = 1'b1;
    wait_drain("t3_drain");

    // T4: flit and credit return with no credit
    cxs.cxs_valid_rx = 1'b1;
    tick();
    cxs.cxs_valid_rx = 1'b0;
    check("t4_proto", DW'(err_proto), DW'(1));
    repeat (2) tick();
    check("t4_no_push", DW'(cxs.rx_valid), '0);
    cxs.cxs_crdrtn_rx = 1'b1;
    err_clr = 1'b1;
    tick();
    cxs.cxs_crdrtn_rx = 1'b0;
    check("t4_clr_loses", DW'(err_proto), DW'(1));
    check("t4_no_underflow", DW'(crd_outstanding), '0);
    tick();
    err_clr = 1'b0;
    check("t4_cleared", DW'(err_proto), '0);

    // T5: parity error still delivers the flit
    cxs.cxs_active_req_rx = 1'b1;
    repeat (20) tick();
    send_flit(1'b1, 1'b0);
    check("t5_parity", DW'(err_parity), DW'(1));
    wait_drain("t5_drain");
    check("t5_no_proto", DW'(err_proto), '0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_parity_clr", DW'(err_parity), '0);

    // T6: asynchronous reset with buffered flits
    cxs.rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_flit(1'b0, 1'b0);
    repeat (3) tick();
    check("t6_buffered", DW'(cxs.rx_valid), DW'(1));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_rx_valid", DW'(cxs.rx_valid), '0);
    check("t6_gnt", DW'(cxs.cxs_crdgnt_rx), '0);
    check("t6_ack", DW'(cxs.cxs_active_ack_rx), '0);
    check("t6_crd", DW'(crd_outstanding), '0);
    sb_q.delete();
    used = 0;
    cxs.cxs_active_req_rx = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("t6_after_rx_valid", DW'(cxs.rx_valid), '0);
    check("t6_after_state", DW'(link_state), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
